// File: rtl/fpu_shared_arbiter_if.sv
// FPU sizing/opcode package plus the requester/FPU-facing bundle of the shared FPU arbiter.
// The slave modport is the arbiter; the master modport is whatever drives requesters and the FPU.
package fpu_defs;
  localparam int C_OP    = 32;
  localparam int C_CMD   = 4;
  localparam int C_RM    = 3;
  localparam int C_PC    = 5;
  localparam int C_FFLAG = 5;

  localparam logic [C_CMD-1:0] C_FPU_ADD_CMD    = 4'h0;
  localparam logic [C_CMD-1:0] C_FPU_SUB_CMD    = 4'h1;
  localparam logic [C_CMD-1:0] C_FPU_MUL_CMD    = 4'h2;
  localparam logic [C_CMD-1:0] C_FPU_DIV_CMD    = 4'h3;
  localparam logic [C_CMD-1:0] C_FPU_I2F_CMD    = 4'h4;
  localparam logic [C_CMD-1:0] C_FPU_F2I_CMD    = 4'h5;
  localparam logic [C_CMD-1:0] C_FPU_SQRT_CMD   = 4'h6;
  localparam logic [C_CMD-1:0] C_FPU_NOP_CMD    = 4'h7;
  localparam logic [C_CMD-1:0] C_FPU_FMADD_CMD  = 4'h8;
  localparam logic [C_CMD-1:0] C_FPU_FMSUB_CMD  = 4'h9;
  localparam logic [C_CMD-1:0] C_FPU_FNMADD_CMD = 4'hA;
  localparam logic [C_CMD-1:0] C_FPU_FNMSUB_CMD = 4'hB;

  typedef enum logic [1:0] {CLS_CORE, CLS_FMA, CLS_DIVSQRT, CLS_NONE} op_cls_e;
endpackage

interface fpu_shared_arbiter_if #(parameter int NUM_REQ = 4);
  import fpu_defs::*;

  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ-1:0]            gnt_o;
  logic [NUM_REQ-1:0][C_OP-1:0]  req_op_a_i;
  logic [NUM_REQ-1:0][C_OP-1:0]  req_op_b_i;
  logic [NUM_REQ-1:0][C_OP-1:0]  req_op_c_i;
  logic [NUM_REQ-1:0][C_CMD-1:0] req_cmd_i;
  logic [NUM_REQ-1:0][C_RM-1:0]  req_rm_i;
  logic [NUM_REQ-1:0][C_PC-1:0]  req_prec_i;

  logic                          fpu_en_o;
  logic [C_OP-1:0]               fpu_op_a_o;
  logic [C_OP-1:0]               fpu_op_b_o;
  logic [C_OP-1:0]               fpu_op_c_o;
  logic [C_CMD-1:0]              fpu_cmd_o;
  logic [C_RM-1:0]               fpu_rm_o;
  logic [C_PC-1:0]               fpu_prec_o;
  logic [C_OP-1:0]               fpu_result_i;
  logic                          fpu_valid_i;
  logic [C_FFLAG-1:0]            fpu_flags_i;
  logic                          fpu_divsqrt_busy_i;

  logic [NUM_REQ-1:0]            resp_valid_o;
  logic [C_OP-1:0]               resp_result_o;
  logic [C_FFLAG-1:0]            resp_flags_o;
  logic                          err_o;

  modport slave (
    input  req_i, req_op_a_i, req_op_b_i, req_op_c_i, req_cmd_i, req_rm_i, req_prec_i,
    input  fpu_result_i, fpu_valid_i, fpu_flags_i, fpu_divsqrt_busy_i,
    output gnt_o, fpu_en_o, fpu_op_a_o, fpu_op_b_o, fpu_op_c_o, fpu_cmd_o, fpu_rm_o, fpu_prec_o,
    output resp_valid_o, resp_result_o, resp_flags_o, err_o
  );

  modport master (
    output req_i, req_op_a_i, req_op_b_i, req_op_c_i, req_cmd_i, req_rm_i, req_prec_i,
    output fpu_result_i, fpu_valid_i, fpu_flags_i, fpu_divsqrt_busy_i,
    input  gnt_o, fpu_en_o, fpu_op_a_o, fpu_op_b_o, fpu_op_c_o, fpu_cmd_o, fpu_rm_o, fpu_prec_o,
    input  resp_valid_o, resp_result_o, resp_flags_o, err_o
  );
endinterface

// File: rtl/fpu_shared_arbiter.sv
// Round-robin sharing of one FPU between NUM_REQ requesters, with in-order completion
// routing through an ID FIFO and class-change / div-sqrt serialisation.
module fsa_cls_dec
  import fpu_defs::*;
(
  input  logic [C_CMD-1:0] i_cmd,
  output op_cls_e          o_cls
);
  always_comb begin
    o_cls = CLS_NONE;
    case (i_cmd)
      C_FPU_ADD_CMD, C_FPU_SUB_CMD, C_FPU_MUL_CMD,
      C_FPU_I2F_CMD, C_FPU_F2I_CMD:                  o_cls = CLS_CORE;
      C_FPU_FMADD_CMD, C_FPU_FMSUB_CMD,
      C_FPU_FNMADD_CMD, C_FPU_FNMSUB_CMD:            o_cls = CLS_FMA;
      C_FPU_DIV_CMD, C_FPU_SQRT_CMD:                 o_cls = CLS_DIVSQRT;
      default:                                       o_cls = CLS_NONE;
    endcase
  end
endmodule

module fpu_shared_arbiter
  import fpu_defs::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  fpu_shared_arbiter_if.slave bus
);
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTRW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CNTW = PTRW + 1;

  typedef enum logic {S_RUN, S_DWAIT} state_e;

  state_e          r_state, w_state_nxt;
  op_cls_e         r_cur_cls;
  logic [IDXW-1:0] r_rr;
  logic [CNTW-1:0] r_cnt;
  logic [PTRW-1:0] r_wr, r_rd;
  logic [IDXW-1:0] r_fifo [MAX_INFLIGHT];
  logic            r_err;

  op_cls_e         w_cls [NUM_REQ];
  op_cls_e         w_cand_cls;
  logic [IDXW-1:0] w_cand;
  logic            w_cand_vld;
  logic            w_issue, w_pop, w_spur;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    fsa_cls_dec u_dec (.i_cmd(bus.req_cmd_i[g]), .o_cls(w_cls[g]));

    a_legal_cmd: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(bus.req_i[g] && w_cls[g] == CLS_NONE));
  end

  // Scan starts one past the last grant so the previous winner has lowest priority.
  always_comb begin
    logic [IDXW-1:0] j;
    w_cand_vld = 1'b0;
    w_cand     = '0;
    j          = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = IDXW'((int'(r_rr) + k) % NUM_REQ);
      if (!w_cand_vld && bus.req_i[j]) begin
        w_cand_vld = 1'b1;
        w_cand     = j;
      end
    end
  end

  assign w_cand_cls = w_cls[w_cand];

  // Full check uses the registered count, so a same-cycle pop does not free a slot.
  assign w_issue = rst_ni && w_cand_vld && (r_state == S_RUN) && !bus.fpu_divsqrt_busy_i
                && (r_cnt < CNTW'(MAX_INFLIGHT)) && (w_cand_cls != CLS_NONE)
                && ((r_cnt == '0) || (w_cand_cls == r_cur_cls));
  assign w_pop   = rst_ni && bus.fpu_valid_i && (r_cnt != '0);
  assign w_spur  = rst_ni && bus.fpu_valid_i && (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (w_issue && w_cand_cls == CLS_DIVSQRT) w_state_nxt = S_DWAIT;
      S_DWAIT: if (w_pop && r_cnt == CNTW'(1))           w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    bus.gnt_o         = '0;
    bus.fpu_en_o      = w_issue;
    bus.fpu_op_a_o    = '0;
    bus.fpu_op_b_o    = '0;
    bus.fpu_op_c_o    = '0;
    bus.fpu_cmd_o     = '0;
    bus.fpu_rm_o      = '0;
    bus.fpu_prec_o    = '0;
    bus.resp_valid_o  = '0;
    bus.resp_result_o = '0;
    bus.resp_flags_o  = '0;
    if (w_issue) begin
      bus.gnt_o[w_cand] = 1'b1;
      bus.fpu_op_a_o    = bus.req_op_a_i[w_cand];
      bus.fpu_op_b_o    = bus.req_op_b_i[w_cand];
      bus.fpu_op_c_o    = bus.req_op_c_i[w_cand];
      bus.fpu_cmd_o     = bus.req_cmd_i[w_cand];
      bus.fpu_rm_o      = bus.req_rm_i[w_cand];
      bus.fpu_prec_o    = bus.req_prec_i[w_cand];
    end
    if (w_pop) begin
      bus.resp_valid_o[r_fifo[r_rd]] = 1'b1;
      bus.resp_result_o              = bus.fpu_result_i;
      bus.resp_flags_o               = bus.fpu_flags_i;
    end
  end

  assign bus.err_o = r_err & rst_ni;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= S_RUN;
      r_cur_cls <= CLS_CORE;
      r_rr      <= IDXW'(NUM_REQ - 1);
      r_cnt     <= '0;
      r_wr      <= '0;
      r_rd      <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= r_cnt + CNTW'(w_issue) - CNTW'(w_pop);
      if (w_issue) begin
        r_rr      <= w_cand;
        r_cur_cls <= w_cand_cls;
        r_wr      <= r_wr + 1'b1;
      end
      if (w_pop)  r_rd  <= r_rd + 1'b1;
      if (w_spur) r_err <= 1'b1;
    end
  end

  // Owner IDs need no reset: entries are only read between their push and pop.
  always_ff @(posedge clk_i) begin
    if (w_issue) r_fifo[r_wr] <= w_cand;
  end
endmodule

// File: tb/tb_fpu_shared_arbiter.sv
// Directed scenarios plus randomized traffic against a queue-based model of the arbiter.
module tb_fpu_shared_arbiter;
  import fpu_defs::*;
  localparam int N = 4;
  localparam int M = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_shared_arbiter_if #(.NUM_REQ(N)) bus ();
  fpu_shared_arbiter #(.NUM_REQ(N), .MAX_INFLIGHT(M)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic int cls_of(input logic [C_CMD-1:0] c);
    case (c)
      C_FPU_ADD_CMD, C_FPU_SUB_CMD, C_FPU_MUL_CMD, C_FPU_I2F_CMD, C_FPU_F2I_CMD: return 0;
      C_FPU_FMADD_CMD, C_FPU_FMSUB_CMD, C_FPU_FNMADD_CMD, C_FPU_FNMSUB_CMD:      return 1;
      C_FPU_DIV_CMD, C_FPU_SQRT_CMD:                                             return 2;
      default:                                                                   return -1;
    endcase
  endfunction

  // Model: queue of owners in issue order; class of the queue; last granted index.
  int       m_q[$];
  int       m_qcls = 0;
  int       m_last = N - 1;
  bit       m_err = 1'b0;
  bit       mon_en = 1'b0;
  logic [N-1:0] exp_gnt = '0;

  always @(negedge clk) if (mon_en) begin
    int cand;
    bit iss, pop;
    logic [N-1:0] eg, er;
    if (!rst_n) begin
      chk("rst_gnt", bus.gnt_o, 0);
      chk("rst_en", bus.fpu_en_o, 0);
      chk("rst_resp", bus.resp_valid_o, 0);
      chk("rst_err", bus.err_o, 0);
      m_q.delete();
      m_last  = N - 1;
      m_err   = 1'b0;
      exp_gnt = '0;
    end else begin
      cand = -1;
      for (int k = 1; k <= N; k++)
        if (cand < 0 && bus.req_i[(m_last + k) % N]) cand = (m_last + k) % N;
      iss = (cand >= 0) && !bus.fpu_divsqrt_busy_i && (m_q.size() < M);
      if (iss) iss = (cls_of(bus.req_cmd_i[cand]) >= 0) &&
                     (m_q.size() == 0 || (cls_of(bus.req_cmd_i[cand]) == m_qcls && m_qcls != 2));
      pop = bus.fpu_valid_i && (m_q.size() > 0);
      eg = '0;
      er = '0;
      if (iss) eg[cand] = 1'b1;
      if (pop) er[m_q[0]] = 1'b1;
      chk("gnt", bus.gnt_o, eg);
      chk("fpu_en", bus.fpu_en_o, iss);
      if (iss) begin
        chk("op_a", bus.fpu_op_a_o, bus.req_op_a_i[cand]);
        chk("op_b", bus.fpu_op_b_o, bus.req_op_b_i[cand]);
        chk("op_c", bus.fpu_op_c_o, bus.req_op_c_i[cand]);
        chk("cmd_rm_pc", {bus.fpu_cmd_o, bus.fpu_rm_o, bus.fpu_prec_o},
            {bus.req_cmd_i[cand], bus.req_rm_i[cand], bus.req_prec_i[cand]});
      end else begin
        chk("op_idle", bus.fpu_op_a_o | bus.fpu_op_b_o | bus.fpu_op_c_o, 0);
        chk("fld_idle", {bus.fpu_cmd_o, bus.fpu_rm_o, bus.fpu_prec_o}, 0);
      end
      chk("resp_valid", bus.resp_valid_o, er);
      if (pop) begin
        chk("resp_result", bus.resp_result_o, bus.fpu_result_i);
        chk("resp_flags", bus.resp_flags_o, bus.fpu_flags_i);
      end
      chk("err", bus.err_o, m_err);
      if (bus.fpu_valid_i && m_q.size() == 0) m_err = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (iss) begin
        m_q.push_back(cand);
        m_qcls = cls_of(bus.req_cmd_i[cand]);
        m_last = cand;
      end
      exp_gnt = eg;
    end
  end

  // Directed cycle: check grant/response vectors against constants, then advance.
  task automatic step(input string t, input logic [N-1:0] eg, input logic [N-1:0] er);
    @(negedge clk);
    chk({t, "_gnt"}, bus.gnt_o, eg);
    chk({t, "_resp"}, bus.resp_valid_o, er);
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [C_CMD-1:0] c);
    bus.req_i[i]      = 1'b1;
    bus.req_cmd_i[i]  = c;
    bus.req_op_a_i[i] = $urandom;
    bus.req_op_b_i[i] = $urandom;
    bus.req_op_c_i[i] = $urandom;
    bus.req_rm_i[i]   = C_RM'($urandom);
    bus.req_prec_i[i] = C_PC'($urandom);
  endtask

  logic [C_CMD-1:0] cmds [11];

  initial begin
    cmds = '{C_FPU_ADD_CMD, C_FPU_SUB_CMD, C_FPU_MUL_CMD, C_FPU_I2F_CMD, C_FPU_F2I_CMD,
             C_FPU_FMADD_CMD, C_FPU_FMSUB_CMD, C_FPU_FNMADD_CMD, C_FPU_FNMSUB_CMD,
             C_FPU_DIV_CMD, C_FPU_SQRT_CMD};
    bus.req_i = '0; bus.req_op_a_i = '0; bus.req_op_b_i = '0; bus.req_op_c_i = '0;
    bus.req_cmd_i = '0; bus.req_rm_i = '0; bus.req_prec_i = '0;
    bus.fpu_result_i = '0; bus.fpu_valid_i = 1'b0; bus.fpu_flags_i = '0;
    bus.fpu_divsqrt_busy_i = 1'b0;
    #1 mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step("reset", 4'b0000, 4'b0000);

    // All four ADD at once, FPU latency 2.
    for (int i = 0; i < N; i++) set_req(i, C_FPU_ADD_CMD);
    for (int k = 0; k < 6; k++) begin
      logic [N-1:0] eg, er;
      eg = '0; er = '0;
      if (k < 4) eg[k] = 1'b1;
      if (k >= 2) er[k-2] = 1'b1;
      bus.fpu_valid_i  = (k >= 2);
      bus.fpu_result_i = 32'h100 + k;
      bus.fpu_flags_i  = C_FFLAG'(k);
      @(negedge clk);
      chk("t1_gnt", bus.gnt_o, eg);
      chk("t1_resp", bus.resp_valid_o, er);
      chk("t1_result", bus.resp_result_o, (k >= 2) ? 32'h100 + k : 32'h0);
      @(posedge clk);
      #1;
      if (k < 4) bus.req_i[k] = 1'b0;
    end
    bus.fpu_valid_i = 1'b0;

    // Spurious completion, then a burst broken by one reset edge.
    bus.fpu_valid_i = 1'b1;
    step("t6_spur", 4'b0000, 4'b0000);
    bus.fpu_valid_i = 1'b0;
    @(negedge clk);
    chk("t6_err_set", bus.err_o, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) set_req(i, C_FPU_ADD_CMD);
    step("t6_b0", 4'b0001, 4'b0000);
    step("t6_b1", 4'b0010, 4'b0000);
    rst_n = 1'b0;
    bus.fpu_valid_i = 1'b1;
    step("t6_rst", 4'b0000, 4'b0000);
    rst_n = 1'b1;
    bus.fpu_valid_i = 1'b0;
    @(negedge clk);
    chk("t6_err_clr", bus.err_o, 0);
    chk("t6_gnt_after", bus.gnt_o, 4'b0001);
    @(posedge clk);
    #1;
    bus.req_i = '0;
    bus.fpu_valid_i = 1'b1;
    step("t6_drain", 4'b0000, 4'b0001);
    bus.fpu_valid_i = 1'b0;

    // FIFO full with the FPU stalled; a pop does not free a slot the same cycle.
    set_req(0, C_FPU_ADD_CMD);
    for (int k = 0; k < 7; k++) begin
      bus.fpu_valid_i = (k == 5);
      step("t5", (k < 4 || k == 6) ? 4'b0001 : 4'b0000, (k == 5) ? 4'b0001 : 4'b0000);
    end
    bus.req_i = '0;
    bus.fpu_valid_i = 1'b1;
    repeat (4) step("t5_drain", 4'b0000, 4'b0001);
    bus.fpu_valid_i = 1'b0;

    // MUL in flight blocks an FMADD until it drains.
    set_req(0, C_FPU_MUL_CMD);
    step("t3_mul", 4'b0001, 4'b0000);
    bus.req_i[0] = 1'b0;
    set_req(1, C_FPU_FMADD_CMD);
    repeat (3) step("t3_wait", 4'b0000, 4'b0000);
    bus.fpu_valid_i = 1'b1;
    step("t3_pop", 4'b0000, 4'b0001);
    bus.fpu_valid_i = 1'b0;
    step("t3_fma", 4'b0010, 4'b0000);
    bus.req_i[1] = 1'b0;
    bus.fpu_valid_i = 1'b1;
    step("t3_done", 4'b0000, 4'b0010);
    bus.fpu_valid_i = 1'b0;

    // DIV blocks everything until its completion.
    set_req(2, C_FPU_DIV_CMD);
    step("t4_div", 4'b0100, 4'b0000);
    bus.req_i[2] = 1'b0;
    set_req(0, C_FPU_ADD_CMD);
    bus.fpu_divsqrt_busy_i = 1'b1;
    repeat (12) step("t4_busy", 4'b0000, 4'b0000);
    bus.fpu_divsqrt_busy_i = 1'b0;
    bus.fpu_valid_i = 1'b1;
    step("t4_pop", 4'b0000, 4'b0100);
    bus.fpu_valid_i = 1'b0;
    step("t4_add", 4'b0001, 4'b0000);
    bus.req_i[0] = 1'b0;
    bus.fpu_valid_i = 1'b1;
    step("t4_done", 4'b0000, 4'b0001);
    bus.fpu_valid_i = 1'b0;

    // Randomized traffic, checked entirely by the model.
    for (int c = 0; c < 3000; c++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (exp_gnt[i]) bus.req_i[i] = 1'b0;
        if (!bus.req_i[i] && $urandom_range(0, 2) == 0)
          set_req(i, cmds[$urandom_range(0, 10)]);
      end
      bus.fpu_divsqrt_busy_i = ($urandom_range(0, 4) == 0);
      bus.fpu_valid_i  = (m_q.size() > 0) ? ($urandom_range(0, 1) == 1)
                                          : ($urandom_range(0, 99) == 0);
      bus.fpu_result_i = $urandom;
      bus.fpu_flags_i  = C_FFLAG'($urandom);
      @(posedge clk);
      #1;
    end
    bus.req_i = '0;
    bus.fpu_valid_i = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
